// File: rtl/register_bank_multimode.sv
// Parametrised general-purpose/address register bank: NUM_REGS x WIDTH registers sharing one
// input bus and one FunSel operation, with sticky per-register wrap flags and two read ports.
module register_bank_multimode #(
    parameter int unsigned    WIDTH       = 32,
    parameter int unsigned    NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WIDTH-1:0]            I,
    input  logic [NUM_REGS-1:0]         E,
    input  logic [3:0]                  FunSel,
    input  logic                        FlagClr,
    input  logic [$clog2(NUM_REGS)-1:0] OutASel,
    input  logic [$clog2(NUM_REGS)-1:0] OutBSel,
    output logic [WIDTH-1:0]            OutA,
    output logic [WIDTH-1:0]            OutB,
    output logic [NUM_REGS-1:0]         Wrap
);

    localparam int unsigned H = WIDTH / 2;

    typedef enum logic [3:0] {
        OP_DEC    = 4'b0000,
        OP_INC    = 4'b0001,
        OP_LOAD   = 4'b0010,
        OP_CLR    = 4'b0011,
        OP_ZX8    = 4'b0100,
        OP_ZXH    = 4'b0101,
        OP_SHLB   = 4'b0110,
        OP_SXH    = 4'b0111,
        OP_SX8    = 4'b1000,
        OP_SHRB   = 4'b1001,
        OP_ROL    = 4'b1010,
        OP_ADD    = 4'b1011,
        OP_SUB    = 4'b1100
    } op_e;

    op_e op;
    assign op = op_e'(FunSel);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]            wrap_q, wrap_d;
    logic [WIDTH-1:0]               q;
    logic [WIDTH:0]                 sum;

    // FlagClr is the baseline for every flag; an enabled set event later in the loop overrides it.
    always_comb begin
        regs_d = regs_q;
        wrap_d = FlagClr ? '0 : wrap_q;
        q      = '0;
        sum    = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            q = regs_q[k];
            if (E[k]) begin
                case (op)
                    OP_DEC: begin
                        regs_d[k] = q - STEP;
                        if (STEP > q) wrap_d[k] = 1'b1;
                    end
                    OP_INC: begin
                        sum       = {1'b0, q} + {1'b0, STEP};
                        regs_d[k] = sum[WIDTH-1:0];
                        if (sum[WIDTH]) wrap_d[k] = 1'b1;
                    end
                    OP_LOAD: regs_d[k] = I;
                    OP_CLR: begin
                        regs_d[k] = '0;
                        wrap_d[k] = 1'b0;
                    end
                    OP_ZX8:  regs_d[k] = {{(WIDTH-8){1'b0}}, I[7:0]};
                    OP_ZXH:  regs_d[k] = {{(WIDTH-H){1'b0}}, I[H-1:0]};
                    OP_SHLB: regs_d[k] = {q[WIDTH-9:0], I[7:0]};
                    OP_SXH:  regs_d[k] = {{(WIDTH-H){I[H-1]}}, I[H-1:0]};
                    OP_SX8:  regs_d[k] = {{(WIDTH-8){I[7]}}, I[7:0]};
                    OP_SHRB: regs_d[k] = {I[7:0], q[WIDTH-1:8]};
                    OP_ROL:  regs_d[k] = {q[WIDTH-2:0], q[WIDTH-1]};
                    OP_ADD: begin
                        sum       = {1'b0, q} + {1'b0, I};
                        regs_d[k] = sum[WIDTH-1:0];
                        if (sum[WIDTH]) wrap_d[k] = 1'b1;
                    end
                    OP_SUB: begin
                        regs_d[k] = q - I;
                        if (I > q) wrap_d[k] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            regs_q <= {NUM_REGS{RESET_VALUE}};
            wrap_q <= '0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    // Out-of-range selects (non-power-of-two NUM_REGS) read as zero.
    assign OutA = (32'(OutASel) < NUM_REGS) ? regs_q[OutASel] : '0;
    assign OutB = (32'(OutBSel) < NUM_REGS) ? regs_q[OutBSel] : '0;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_register_bank_multimode.sv
// Directed table-driven bench for register_bank_multimode (default parameters) with
// hand-written sequences for reset, read timing and mid-cycle reset.
module tb_register_bank_multimode;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] I;
    logic [3:0]  E;
    logic [3:0]  FunSel;
    logic        FlagClr;
    logic [1:0]  OutASel, OutBSel;
    logic [31:0] OutA, OutB;
    logic [3:0]  Wrap;

    int checks = 0;
    int errors = 0;

    register_bank_multimode #(
        .WIDTH(32),
        .NUM_REGS(4),
        .STEP(32'd1),
        .RESET_VALUE(32'd0)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .I(I),
        .E(E),
        .FunSel(FunSel),
        .FlagClr(FlagClr),
        .OutASel(OutASel),
        .OutBSel(OutBSel),
        .OutA(OutA),
        .OutB(OutB),
        .Wrap(Wrap)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  e;
        logic [3:0]  fs;
        logic [31:0] i;
        logic        fclr;
        logic [1:0]  sel_a;
        logic [31:0] exp_a;
        logic [1:0]  sel_b;
        logic [31:0] exp_b;
        logic [3:0]  exp_wrap;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic [3:0] fs, input logic [31:0] i,
                         input logic fclr, input logic [1:0] sa, input logic [1:0] sb);
        @(negedge Clock);
        E = e; FunSel = fs; I = i; FlagClr = fclr; OutASel = sa; OutBSel = sb;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 4'b0001, 32'h0,        1'b0, 2'd0, 32'h00000000, 2'd1, 32'hFFFFFFFF, 4'b0001};
        vecs[1]  = '{4'b0001, 4'b0000, 32'h0,        1'b0, 2'd0, 32'hFFFFFFFF, 2'd2, 32'hFFFFFFFF, 4'b0001};
        vecs[2]  = '{4'b0001, 4'b0011, 32'h0,        1'b0, 2'd0, 32'h00000000, 2'd3, 32'hFFFFFFFF, 4'b0000};
        vecs[3]  = '{4'b0010, 4'b0010, 32'h12345678, 1'b0, 2'd1, 32'h12345678, 2'd0, 32'h00000000, 4'b0000};
        vecs[4]  = '{4'b0010, 4'b0110, 32'h000000AB, 1'b0, 2'd1, 32'h345678AB, 2'd2, 32'hFFFFFFFF, 4'b0000};
        vecs[5]  = '{4'b0010, 4'b1001, 32'h000000AB, 1'b0, 2'd1, 32'hAB345678, 2'd3, 32'hFFFFFFFF, 4'b0000};
        vecs[6]  = '{4'b0010, 4'b1010, 32'h000000AB, 1'b0, 2'd1, 32'h5668ACF1, 2'd0, 32'h00000000, 4'b0000};
        vecs[7]  = '{4'b0100, 4'b0111, 32'h00008001, 1'b0, 2'd2, 32'hFFFF8001, 2'd1, 32'h5668ACF1, 4'b0000};
        vecs[8]  = '{4'b0100, 4'b0101, 32'h00008001, 1'b0, 2'd2, 32'h00008001, 2'd3, 32'hFFFFFFFF, 4'b0000};
        vecs[9]  = '{4'b0100, 4'b1000, 32'h00000080, 1'b0, 2'd2, 32'hFFFFFF80, 2'd0, 32'h00000000, 4'b0000};
        vecs[10] = '{4'b0100, 4'b0100, 32'h123456C3, 1'b0, 2'd2, 32'h000000C3, 2'd1, 32'h5668ACF1, 4'b0000};
        vecs[11] = '{4'b1000, 4'b0010, 32'h00000005, 1'b0, 2'd3, 32'h00000005, 2'd2, 32'h000000C3, 4'b0000};
        vecs[12] = '{4'b1000, 4'b1100, 32'h00000007, 1'b1, 2'd3, 32'hFFFFFFFE, 2'd0, 32'h00000000, 4'b1000};
        vecs[13] = '{4'b1000, 4'b1011, 32'h00000003, 1'b0, 2'd3, 32'h00000001, 2'd1, 32'h5668ACF1, 4'b1000};
        vecs[14] = '{4'b0001, 4'b0000, 32'h0,        1'b0, 2'd0, 32'hFFFFFFFF, 2'd3, 32'h00000001, 4'b1001};
        vecs[15] = '{4'b0001, 4'b1011, 32'h00000001, 1'b1, 2'd0, 32'h00000000, 2'd3, 32'h00000001, 4'b0001};
        vecs[16] = '{4'b0000, 4'b0001, 32'h0,        1'b1, 2'd0, 32'h00000000, 2'd2, 32'h000000C3, 4'b0000};
        vecs[17] = '{4'b0010, 4'b1011, 32'h10000000, 1'b0, 2'd1, 32'h6668ACF1, 2'd3, 32'h00000001, 4'b0000};
        vecs[18] = '{4'b0010, 4'b1100, 32'h6668ACF1, 1'b0, 2'd1, 32'h00000000, 2'd0, 32'h00000000, 4'b0000};
        vecs[19] = '{4'b0100, 4'b1110, 32'h0000DEAD, 1'b0, 2'd2, 32'h000000C3, 2'd1, 32'h00000000, 4'b0000};
        vecs[20] = '{4'b1111, 4'b1111, 32'h0000FFFF, 1'b0, 2'd3, 32'h00000001, 2'd2, 32'h000000C3, 4'b0000};
        vecs[21] = '{4'b1111, 4'b0001, 32'h0,        1'b0, 2'd2, 32'h000000C4, 2'd3, 32'h00000002, 4'b0000};
        vecs[22] = '{4'b1111, 4'b1100, 32'h00000002, 1'b0, 2'd0, 32'hFFFFFFFF, 2'd3, 32'h00000000, 4'b0011};
        vecs[23] = '{4'b0101, 4'b0011, 32'h0,        1'b0, 2'd0, 32'h00000000, 2'd1, 32'hFFFFFFFF, 4'b0010};
        vecs[24] = '{4'b0010, 4'b1101, 32'h0,        1'b0, 2'd1, 32'hFFFFFFFF, 2'd2, 32'h00000000, 4'b0010};

        // Reset held across clock edges with a load pending: nothing may be written.
        Reset = 1'b0; E = 4'b1111; FunSel = 4'b0010; I = 32'hFFFFFFFF; FlagClr = 1'b0;
        OutASel = 2'd0; OutBSel = 2'd1;
        repeat (3) @(posedge Clock);
        #1;
        for (int r = 0; r < 4; r++) begin
            OutASel = 2'(r);
            #1 check("reset_reg", OutA, 32'h0);
        end
        check("reset_wrap", {28'h0, Wrap}, 32'h0);

        @(negedge Clock) Reset = 1'b1;
        @(posedge Clock); #1;
        for (int r = 0; r < 4; r++) begin
            OutBSel = 2'(r);
            #1 check("first_load", OutB, 32'hFFFFFFFF);
        end

        foreach (vecs[n]) begin
            drive(vecs[n].e, vecs[n].fs, vecs[n].i, vecs[n].fclr, vecs[n].sel_a, vecs[n].sel_b);
            @(posedge Clock); #1;
            check($sformatf("vec%0d_outa", n), OutA, vecs[n].exp_a);
            check($sformatf("vec%0d_outb", n), OutB, vecs[n].exp_b);
            check($sformatf("vec%0d_wrap", n), {28'h0, Wrap}, {28'h0, vecs[n].exp_wrap});
        end

        // No write-through: OutA shows the old R0 until the edge commits the load.
        drive(4'b0011, 4'b0010, 32'hCAFEBABE, 1'b0, 2'd0, 2'd2);
        #1 check("no_bypass_before", OutA, 32'h0);
        @(posedge Clock); #1;
        check("load_r0_after", OutA, 32'hCAFEBABE);
        check("r2_untouched", OutB, 32'h0);
        OutBSel = 2'd3;
        #1 check("r3_untouched", OutB, 32'h0);
        OutASel = 2'd1;
        #1 check("load_r1_after", OutA, 32'hCAFEBABE);

        drive(4'b1111, 4'b1110, 32'h12345678, 1'b0, 2'd0, 2'd1);
        @(posedge Clock); #1;
        check("reserved_r0", OutA, 32'hCAFEBABE);
        check("reserved_r1", OutB, 32'hCAFEBABE);
        check("reserved_wrap", {28'h0, Wrap}, 32'h2);

        // Asynchronous reset between edges clears state without a clock edge.
        drive(4'b1111, 4'b0010, 32'h55AA55AA, 1'b0, 2'd0, 2'd1);
        #2 Reset = 1'b0;
        #1 check("async_rst_r0", OutA, 32'h0);
        check("async_rst_r1", OutB, 32'h0);
        check("async_rst_wrap", {28'h0, Wrap}, 32'h0);
        @(posedge Clock); #1;
        check("rst_blocks_edge", OutA, 32'h0);
        @(negedge Clock) Reset = 1'b1;
        @(posedge Clock); #1;
        check("post_rst_edge", OutA, 32'h55AA55AA);
        check("post_rst_edge_b", OutB, 32'h55AA55AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank_multimode.md
Name: register_bank_multimode

Overview:
- Parametrised successor to the single 32-bit function-select register.
- Holds NUM_REGS registers of WIDTH bits, written through a shared input bus.
- Each register whose enable bit is set executes the same FunSel operation on the clock edge.
- Adds arithmetic/shift modes, sticky per-register wrap flags and two combinational read ports; sits in the datapath as the general-purpose/address register bank.

Parameters:
WIDTH, 32, register width in bits; multiple of 8, >= 16
NUM_REGS, 4, number of registers; >= 2
STEP, 1, increment/decrement amount for FunSel 0000/0001; 1 <= STEP < 2^WIDTH
RESET_VALUE, 0, value loaded into every register on reset

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
I  input  WIDTH  shared data input
E  input  NUM_REGS  per-register write-enable mask; bit k enables register k
FunSel  input  4  operation select, applied to all enabled registers
FlagClr  input  1  synchronous clear of all wrap flags
OutASel  input  clog2(NUM_REGS)  read port A select
OutBSel  input  clog2(NUM_REGS)  read port B select
OutA  output  WIDTH  contents of register OutASel
OutB  output  WIDTH  contents of register OutBSel
Wrap  output  NUM_REGS  sticky wrap flag per register

Behaviour:
- Clock is Clock; reset is asynchronous and active-low (Reset).
- Reset=0: all registers = RESET_VALUE and Wrap = 0, immediately and independent of Clock; overrides every other input.
- Registers update only on the rising Clock edge with Reset=1. E[k]=0 holds register k and its flag.
- H = WIDTH/2. Byte = 8 bits. All arithmetic is modulo 2^WIDTH.
- FunSel codes (Q = register k before the edge):
  0000 Q-STEP; 0001 Q+STEP; 0010 I; 0011 0 (also clears Wrap[k]).
  0100 zero-extended I[7:0]; 0101 zero-extended I[H-1:0].
  0110 {Q[WIDTH-9:0], I[7:0]} (shift left one byte, insert at bottom).
  0111 I[H-1:0] sign-extended from bit H-1.
  1000 I[7:0] sign-extended from bit 7.
  1001 {I[7:0], Q[WIDTH-1:8]} (shift right one byte, insert at top).
  1010 rotate left by 1 bit.
  1011 Q+I; 1100 Q-I.
  1101-1111 reserved: hold Q and flag.
- Wrap[k] set on the edge when an enabled op wraps:
  - 0001/1011 when the true sum >= 2^WIDTH;
  - 0000/1100 when the subtrahend > Q.
- Wrap is sticky. It clears on FlagClr=1 (all flags) or on op 0011 (enabled registers only).
- Same edge, set event vs FlagClr: the set event wins for that register; other registers clear.
- Reads are combinational from register state. A write is visible on OutA/OutB the cycle after the edge; there is no write-through bypass.
- Select >= NUM_REGS (non-power-of-two NUM_REGS) drives that output to 0.
- Several enabled registers each apply the op to their own Q independently.
- Reset asserted mid-cycle wins over any pending edge; the first edge after release executes normally.

Test Plan:
- Reset=0 with E=1111, FunSel=0010, I=FFFFFFFF, clocking -> all regs 0, Wrap=0000; release, one edge -> all regs FFFFFFFF.
- R0=FFFFFFFF, E=0001, FunSel=0001 -> R0=00000000, Wrap=0001; FunSel=0000 -> R0=FFFFFFFF, Wrap stays 0001; FunSel=0011 -> R0=0, Wrap=0000.
- R1=12345678, E=0010, I=000000AB: FunSel=0110 -> R1=345678AB; FunSel=1001 -> R1=AB345678; FunSel=1010 -> R1=5668ACF1.
- I=0000_8001, E=0100: FunSel=0111 -> R2=FFFF8001; FunSel=0101 -> R2=00008001; I=00000080, FunSel=1000 -> R2=FFFFFF80.
- R3=00000005, E=1000, I=00000007, FunSel=1100, FlagClr=1 same edge -> R3=FFFFFFFE, Wrap[3]=1 (set wins).
- E=0011, FunSel=0010, I=CAFEBABE, OutASel=0: OutA shows old R0 until the edge, CAFEBABE after; R2/R3 unchanged; FunSel=1110 -> no change.
